// File: rtl/sequential_divider.sv
// Signed restoring divider producing one quotient bit per clock.
// Results are reported as unsigned magnitudes plus a quotient sign flag, the same
// format the sequential multiplier uses, so both can share one display path.
module sequential_divider #(
    parameter int unsigned LENGTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LENGTH-1:0] dividend,
    input  logic [LENGTH-1:0] divisor,
    output logic [LENGTH-1:0] quotient,
    output logic [LENGTH-1:0] remainder,
    output logic              Computing,
    output logic              Ready,
    output logic              Negative,
    output logic              DivByZero
);

    // Step counter only needs to reach LENGTH-1.
    localparam int unsigned CW = $clog2(LENGTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CW-1:0]     count;
    // Shifts dividend bits out of the top while quotient bits enter at the bottom.
    logic [LENGTH-1:0] work;
    logic [LENGTH-1:0] dvs_mag;
    logic [LENGTH:0]   prem;
    logic              sign_dvd;
    logic              sign_dvs;
    logic              dz;

    logic [LENGTH-1:0] dvd_abs;
    logic [LENGTH-1:0] dvs_abs;
    logic [LENGTH:0]   shifted;
    logic [LENGTH:0]   trial;
    logic              trial_ok;
    logic              divisor_zero;

    // Operand magnitudes; the most-negative value maps onto its unsigned magnitude.
    always_comb begin
        dvd_abs      = dividend[LENGTH-1] ? ((~dividend) + LENGTH'(1)) : dividend;
        dvs_abs      = divisor[LENGTH-1]  ? ((~divisor)  + LENGTH'(1)) : divisor;
        divisor_zero = (divisor == '0);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted  = {prem[LENGTH-1:0], work[LENGTH-1]};
        trial    = shifted - {1'b0, dvs_mag};
        trial_ok = ~trial[LENGTH];
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a zero divisor skips the iteration entirely.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = divisor_zero ? SIGN : CALC;
                end
            end
            CALC: begin
                if (count == CW'(LENGTH - 1)) begin
                    next_state = SIGN;
                end
            end
            SIGN:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            work      <= '0;
            dvs_mag   <= '0;
            prem      <= '0;
            sign_dvd  <= 1'b0;
            sign_dvs  <= 1'b0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            Computing <= 1'b0;
            Ready     <= 1'b0;
            Negative  <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work      <= dvd_abs;
                        dvs_mag   <= dvs_abs;
                        sign_dvd  <= dividend[LENGTH-1];
                        sign_dvs  <= divisor[LENGTH-1];
                        dz        <= divisor_zero;
                        prem      <= '0;
                        count     <= '0;
                        Computing <= 1'b1;
                        Ready     <= 1'b0;
                        Negative  <= 1'b0;
                        DivByZero <= 1'b0;
                    end
                end
                CALC: begin
                    prem  <= trial_ok ? trial : shifted;
                    work  <= {work[LENGTH-2:0], trial_ok};
                    count <= count + CW'(1);
                end
                SIGN: begin
                    // On divide-by-zero work still holds the untouched |dividend|.
                    quotient  <= dz ? '1 : work;
                    remainder <= dz ? work : prem[LENGTH-1:0];
                    Negative  <= !dz && (sign_dvd ^ sign_dvs) && (work != '0);
                    DivByZero <= dz;
                    Computing <= 1'b0;
                    Ready     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and randomized checks of sequential_divider against a behavioural model.
module tb_sequential_divider;

    localparam int unsigned LENGTH  = 8;
    localparam int          MAXWAIT = 40;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       neg;
        logic       dz;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       Computing;
    logic       Ready;
    logic       Negative;
    logic       DivByZero;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    sequential_divider #(.LENGTH(LENGTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .Computing (Computing),
        .Ready     (Ready),
        .Negative  (Negative),
        .DivByZero (DivByZero)
    );

    always #5 clock = ~clock;

    // Behavioural reference: truncating division on magnitudes.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   ma;
        int   mb;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        if (mb == 0) begin
            e.q   = 8'hFF;
            e.r   = 8'(ma);
            e.neg = 1'b0;
            e.dz  = 1'b1;
        end else begin
            e.q   = 8'(ma / mb);
            e.r   = 8'(ma % mb);
            e.neg = ((a < 0) != (b < 0)) && ((ma / mb) != 0);
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=no_entry expected=scoreboard_entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"},   32'(quotient),  32'(e.q));
            check({tag, "_r"},   32'(remainder), 32'(e.r));
            check({tag, "_neg"}, 32'(Negative),  32'(e.neg));
            check({tag, "_dz"},  32'(DivByZero), 32'(e.dz));
        end
    endtask

    // Drive one request; returns right after the accepting edge.
    task automatic accept(input int a, input int b, input string tag);
        @(negedge clock);
        dividend = 8'(a);
        divisor  = 8'(b);
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clock);
        #1;
        start = 1'b0;
        check({tag, "_busy"},     32'(Computing), 32'd1);
        check({tag, "_notready"}, 32'(Ready),     32'd0);
    endtask

    // Count edges after acceptance until Ready, then compare against the scoreboard.
    task automatic wait_ready(input int exp_lat, input string tag);
        int n;
        n = 0;
        while (n < MAXWAIT) begin
            @(posedge clock);
            #1;
            n++;
            if (Ready) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_idle"}, 32'(Computing), 32'd0);
        check_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_q",    32'(quotient),  32'd0);
        check("rst_r",    32'(remainder), 32'd0);
        check("rst_busy", 32'(Computing), 32'd0);
        check("rst_rdy",  32'(Ready),     32'd0);
        check("rst_neg",  32'(Negative),  32'd0);
        check("rst_dz",   32'(DivByZero), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        accept(8, 3, "d8_3");        wait_ready(9, "d8_3");
        accept(-7, 2, "dm7_2");      wait_ready(9, "dm7_2");
        accept(-128, -1, "dm128_m1"); wait_ready(9, "dm128_m1");
        accept(0, -5, "d0_m5");      wait_ready(9, "d0_m5");
        // Divide by zero: SIGN runs on the edge right after acceptance.
        accept(5, 0, "d5_0");        wait_ready(1, "d5_0");
        accept(-128, 127, "dm128_127"); wait_ready(9, "dm128_127");

        // Reset during the fourth CALC cycle aborts the operation.
        accept(50, 3, "abort");
        sb.delete();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_q",    32'(quotient),  32'd0);
        check("abort_r",    32'(remainder), 32'd0);
        check("abort_busy", 32'(Computing), 32'd0);
        check("abort_rdy",  32'(Ready),     32'd0);
        check("abort_neg",  32'(Negative),  32'd0);
        check("abort_dz",   32'(DivByZero), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        accept(100, 7, "d100_7");    wait_ready(9, "d100_7");

        // start held for 20 edges: ignored while busy, re-accepted from DONE.
        @(negedge clock);
        dividend = 8'd9;
        divisor  = 8'd4;
        start    = 1'b1;
        sb.push_back(model(9, 4));
        for (int e = 0; e < 20; e++) begin
            @(posedge clock);
            #1;
            if (e == 0) begin
                check("held_busy0", 32'(Computing), 32'd1);
                dividend = 8'(-100);
            end
            if (e == 8) check("held_notready", 32'(Ready), 32'd0);
            if (e == 9) begin
                check("held_ready1", 32'(Ready), 32'd1);
                check_result("held1");
                dividend = 8'd9;
            end
            if (e == 10) begin
                check("held_reaccept", 32'(Ready), 32'd0);
                check("held_busy1", 32'(Computing), 32'd1);
                sb.push_back(model(9, 4));
                dividend = 8'(-100);
            end
            if (e == 19) begin
                check("held_ready2", 32'(Ready), 32'd1);
                check_result("held2");
                start = 1'b0;
            end
        end
        repeat (2) @(posedge clock);
        #1;
        check("done_hold_rdy", 32'(Ready),    32'd1);
        check("done_hold_q",   32'(quotient), 32'd2);

        // Randomized operands, including the occasional zero divisor.
        for (int i = 0; i < 12; i++) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = (i % 5 == 4) ? 0 : int'($urandom_range(0, 255)) - 128;
            accept(a, b, "rnd");
            wait_ready((b == 0) ? 1 : 9, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
